// File: rtl/renkon_winbuf_pkg.sv
// Shared state encodings, default widths and flat window-bus indexing for renkon_winbuf.
package renkon_winbuf_pkg;

  localparam int DWIDTH_DEF = 16;
  localparam int LWIDTH_DEF = 10;
  localparam int FWIDTH_DEF = 3;
  localparam int MAXFIL_DEF = 5;
  localparam int AWIDTH_DEF = 5;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_CHARGE = 2'd1,
    S_ACTIVE = 2'd2
  } state_t;

  // Bit offset of window element (r,c) on the flat bus; r=0 oldest row, c=0 leftmost column.
  function automatic int win_idx(input int r, input int c, input int maxfil, input int dwidth);
    return (r * maxfil + c) * dwidth;
  endfunction

endpackage

// File: rtl/renkon_mem_winbuf.sv
// One line bank: single-port RAM, synchronous write, registered read (1 cycle).
// Contents are never reset; every frame rewrites each row before it is used.
module renkon_mem_winbuf
  import renkon_winbuf_pkg::*;
#(
  parameter int DWIDTH = DWIDTH_DEF,
  parameter int AWIDTH = AWIDTH_DEF
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [AWIDTH-1:0] i_addr,
  input  logic [DWIDTH-1:0] i_wdat,
  output logic [DWIDTH-1:0] o_rdat
);

  logic [DWIDTH-1:0] r_mem [2**AWIDTH];
  logic [DWIDTH-1:0] r_rdat;

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_addr] <= i_wdat;
    end
    r_rdat <= r_mem[i_addr];
  end

  assign o_rdat = r_rdat;

endmodule

// File: rtl/renkon_winbuf.sv
// Sliding-window line buffer: row-major pixel stream in, FS x FS window out on a flat bus.
// Latency 2 cycles from accept to out_valid; in_valid low stalls input, output has no backpressure.
module renkon_winbuf
  import renkon_winbuf_pkg::*;
#(
  parameter int DWIDTH = DWIDTH_DEF,
  parameter int LWIDTH = LWIDTH_DEF,
  parameter int FWIDTH = FWIDTH_DEF,
  parameter int MAXFIL = MAXFIL_DEF,
  parameter int AWIDTH = AWIDTH_DEF
) (
  input  logic                            clk,
  input  logic                            xrst,
  input  logic                            buf_en,
  input  logic [LWIDTH-1:0]               img_size,
  input  logic [FWIDTH-1:0]               fil_size,
  input  logic                            in_valid,
  input  logic signed [DWIDTH-1:0]        buf_input,
  output logic [MAXFIL*MAXFIL*DWIDTH-1:0] win_out,
  output logic                            out_valid,
  output logic                            frame_done,
  output logic                            busy
);

  localparam int BW = $clog2(MAXFIL + 1);

  state_t r_state, w_state_nx;

  logic [LWIDTH-1:0] r_is, r_col, r_row;
  logic [BW-1:0]     r_fs, r_wbank, r_wbank_d, w_fs_in, w_fs_m1;
  logic [LWIDTH-1:0] w_is_m1, w_fsl_m1, w_fsl_m2;
  logic              w_start, w_acc, w_col_last, w_row_last;

  logic                     r_acc_d, r_wvld_d, r_last_d, r_ov, r_fd;
  logic signed [DWIDTH-1:0] r_pix_d;

  logic [DWIDTH-1:0]        w_rd   [MAXFIL];
  logic signed [DWIDTH-1:0] w_brow [MAXFIL];
  logic signed [DWIDTH-1:0] r_win  [MAXFIL][MAXFIL];

  assign w_start    = buf_en && (r_state == S_IDLE);
  assign w_acc      = in_valid && ((r_state == S_CHARGE) || (r_state == S_ACTIVE));
  assign w_is_m1    = r_is - LWIDTH'(1);
  assign w_fs_m1    = r_fs - BW'(1);
  assign w_fsl_m1   = LWIDTH'(r_fs) - LWIDTH'(1);
  assign w_fsl_m2   = LWIDTH'(r_fs) - LWIDTH'(2);
  assign w_col_last = (r_col == w_is_m1);
  assign w_row_last = (r_row == w_is_m1);

  // Filter edge 0 behaves as 1; anything above the bank count saturates to MAXFIL.
  always_comb begin
    w_fs_in = BW'(MAXFIL);
    if (fil_size == '0) begin
      w_fs_in = BW'(1);
    end else if (int'(fil_size) <= MAXFIL) begin
      w_fs_in = BW'(fil_size);
    end
  end

  always_ff @(posedge clk or negedge xrst) begin
    if (!xrst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nx;
    end
  end

  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      S_IDLE: begin
        if (buf_en) begin
          w_state_nx = (w_fs_in == BW'(1)) ? S_ACTIVE : S_CHARGE;
        end
      end
      S_CHARGE: begin
        if (w_acc && w_col_last && (r_row == w_fsl_m2)) begin
          w_state_nx = S_ACTIVE;
        end
      end
      S_ACTIVE: begin
        if (w_acc && w_col_last && w_row_last) begin
          w_state_nx = S_IDLE;
        end
      end
      default: w_state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge xrst) begin
    if (!xrst) begin
      r_is    <= '0;
      r_fs    <= '0;
      r_col   <= '0;
      r_row   <= '0;
      r_wbank <= '0;
    end else if (w_start) begin
      r_is    <= img_size;
      r_fs    <= w_fs_in;
      r_col   <= '0;
      r_row   <= '0;
      r_wbank <= '0;
    end else if (w_acc) begin
      if (w_col_last) begin
        r_col   <= '0;
        r_row   <= r_row + LWIDTH'(1);
        r_wbank <= (r_wbank == w_fs_m1) ? '0 : r_wbank + BW'(1);
      end else begin
        r_col <= r_col + LWIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge xrst) begin
    if (!xrst) begin
      r_acc_d   <= 1'b0;
      r_pix_d   <= '0;
      r_wbank_d <= '0;
      r_wvld_d  <= 1'b0;
      r_last_d  <= 1'b0;
      r_ov      <= 1'b0;
      r_fd      <= 1'b0;
    end else begin
      r_acc_d   <= w_acc;
      r_pix_d   <= buf_input;
      r_wbank_d <= r_wbank;
      r_wvld_d  <= (r_row >= w_fsl_m1) && (r_col >= w_fsl_m1);
      r_last_d  <= w_col_last && w_row_last;
      r_ov      <= r_acc_d && r_wvld_d;
      r_fd      <= r_acc_d && r_last_d;
    end
  end

  for (genvar b = 0; b < MAXFIL; b++) begin : g_bank
    renkon_mem_winbuf #(
      .DWIDTH(DWIDTH),
      .AWIDTH(AWIDTH)
    ) u_bank (
      .clk   (clk),
      .i_we  (w_acc && (r_wbank == BW'(b))),
      .i_addr(r_col[AWIDTH-1:0]),
      .i_wdat(buf_input),
      .o_rdat(w_rd[b])
    );
  end

  // Window row r comes from the bank just after the one being written, i.e. the oldest row first.
  for (genvar r = 0; r < MAXFIL; r++) begin : g_bsel
    logic [BW:0]   w_sum;
    logic [BW-1:0] w_sel;
    assign w_sum     = {1'b0, r_wbank_d} + (BW+1)'(r + 1);
    assign w_sel     = (w_sum >= {1'b0, r_fs}) ? BW'(w_sum - {1'b0, r_fs}) : w_sum[BW-1:0];
    assign w_brow[r] = w_rd[w_sel];
  end

  for (genvar r = 0; r < MAXFIL; r++) begin : g_row
    for (genvar c = 0; c < MAXFIL; c++) begin : g_col
      localparam int            CN  = (c < MAXFIL - 1) ? c + 1 : c;
      localparam int            IDX = win_idx(r, c, MAXFIL, DWIDTH);
      localparam logic [BW-1:0] RI  = BW'(r);
      localparam logic [BW-1:0] CI  = BW'(c);
      logic signed [DWIDTH-1:0] w_nx;

      always_comb begin
        w_nx = '0;
        if ((RI < r_fs) && (CI < r_fs)) begin
          if (CI != w_fs_m1) begin
            w_nx = r_win[r][CN];
          end else if (RI == w_fs_m1) begin
            w_nx = r_pix_d;
          end else begin
            w_nx = w_brow[r];
          end
        end
      end

      // A draining pixel of the previous frame takes priority over the clear of a new one.
      always_ff @(posedge clk or negedge xrst) begin
        if (!xrst) begin
          r_win[r][c] <= '0;
        end else if (r_acc_d) begin
          r_win[r][c] <= w_nx;
        end else if (w_start) begin
          r_win[r][c] <= '0;
        end
      end

      assign win_out[IDX +: DWIDTH] = r_win[r][c];
    end
  end

  assign out_valid  = r_ov;
  assign frame_done = r_fd;
  assign busy       = (r_state != S_IDLE) || r_acc_d || r_fd;

endmodule

// File: tb/tb_renkon_winbuf.sv
// Directed bench for renkon_winbuf: scoreboarded windows, latency, frame_done, busy and reset abort.
module tb_renkon_winbuf;

  localparam int DW = 16;
  localparam int LW = 10;
  localparam int FW = 3;
  localparam int MF = 5;
  localparam int AW = 5;
  localparam int WW = MF * MF * DW;

  logic                 clk = 1'b0;
  logic                 xrst = 1'b1;
  logic                 buf_en = 1'b0;
  logic [LW-1:0]        img_size = '0;
  logic [FW-1:0]        fil_size = '0;
  logic                 in_valid = 1'b0;
  logic signed [DW-1:0] buf_input = '0;
  logic [WW-1:0]        win_out;
  logic                 out_valid, frame_done, busy;

  renkon_winbuf #(
    .DWIDTH(DW), .LWIDTH(LW), .FWIDTH(FW), .MAXFIL(MF), .AWIDTH(AW)
  ) dut (
    .clk       (clk),
    .xrst      (xrst),
    .buf_en    (buf_en),
    .img_size  (img_size),
    .fil_size  (fil_size),
    .in_valid  (in_valid),
    .buf_input (buf_input),
    .win_out   (win_out),
    .out_valid (out_valid),
    .frame_done(frame_done),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_bad = 0;

  typedef struct {
    int            cyc;
    logic [WW-1:0] win;
    bit            fd;
    int            fid;
  } exp_t;

  exp_t          q[$];
  exp_t          m_e;
  int            win_cnt[16];
  int            ov_cyc[16][2];
  logic [WW-1:0] first_win[16];
  logic [WW-1:0] last_win[16];

  task automatic chk(input string tag, input logic [WW-1:0] got, input logic [WW-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] el(input logic [WW-1:0] w, input int r, input int c);
    return w[(r*MF+c)*DW +: DW];
  endfunction

  // Window ending at pixel (row,col): rows row-fs+1..row, cols col-fs+1..col, zero outside fs x fs.
  function automatic logic [WW-1:0] mk_win(input int is, input int fs, input int base,
                                           input int row, input int col);
    logic [WW-1:0] w;
    int v;
    w = '0;
    for (int r = 0; r < MF; r++) begin
      for (int c = 0; c < MF; c++) begin
        if (r < fs && c < fs) begin
          v = base + (row - fs + 1 + r) * is + (col - fs + 1 + c);
          w[(r*MF+c)*DW +: DW] = v[DW-1:0];
        end
      end
    end
    return w;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_frame(input int is, input int fsz);
    buf_en   = 1'b1;
    img_size = LW'(is);
    fil_size = FW'(fsz);
    tick();
    buf_en = 1'b0;
  endtask

  task automatic feed(input int fid, input int is, input int fs, input int base,
                      input int npix, input bit stall, input int ben_at);
    int p;
    exp_t e;
    p = 0;
    for (int row = 0; row < is; row++) begin
      for (int col = 0; col < is; col++) begin
        if (p < npix) begin
          if (stall) begin
            in_valid = 1'b0;
            tick();
          end
          in_valid  = 1'b1;
          buf_input = DW'(base + row * is + col);
          if (p == ben_at) begin
            buf_en   = 1'b1;
            img_size = LW'(3);
            fil_size = FW'(2);
          end
          if (row >= fs - 1 && col >= fs - 1) begin
            e.cyc = cyc + 2;
            e.win = mk_win(is, fs, base, row, col);
            e.fd  = (row == is - 1) && (col == is - 1);
            e.fid = fid;
            q.push_back(e);
          end
          tick();
          buf_en = 1'b0;
          p++;
        end
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_drain(input int fid, input int n_exp, input string tag);
    for (int i = 0; i < 300 && (q.size() != 0 || busy); i++) tick();
    chk({tag, " busy_end"}, WW'(busy), WW'(0));
    chk({tag, " queue_empty"}, WW'(q.size()), WW'(0));
    chk({tag, " window_count"}, WW'(win_cnt[fid]), WW'(n_exp));
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (out_valid) begin
        if (q.size() == 0) begin
          chk("spurious_out_valid", WW'(out_valid), WW'(0));
        end else begin
          m_e = q.pop_front();
          chk($sformatf("f%0d window", m_e.fid), win_out, m_e.win);
          chk($sformatf("f%0d latency", m_e.fid), WW'(cyc), WW'(m_e.cyc));
          chk($sformatf("f%0d frame_done", m_e.fid), WW'(frame_done), WW'(m_e.fd));
          if (win_cnt[m_e.fid] < 2) ov_cyc[m_e.fid][win_cnt[m_e.fid]] = cyc;
          if (win_cnt[m_e.fid] == 0) first_win[m_e.fid] = win_out;
          last_win[m_e.fid] = win_out;
          win_cnt[m_e.fid]++;
        end
      end else if (frame_done) begin
        chk("frame_done_without_out_valid", WW'(frame_done), WW'(0));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    #1 xrst = 1'b0;
    tick();
    tick();
    chk("reset win_out", win_out, '0);
    chk("reset out_valid", WW'(out_valid), WW'(0));
    chk("reset frame_done", WW'(frame_done), WW'(0));
    chk("reset busy", WW'(busy), WW'(0));
    xrst = 1'b1;
    tick();

    // IS=8 FS=5, continuous input
    start_frame(8, 5);
    chk("t1 busy_after_start", WW'(busy), WW'(1));
    feed(1, 8, 5, 0, 64, 1'b0, -1);
    wait_drain(1, 16, "t1");
    chk("t1 first(0,0)", WW'(el(first_win[1], 0, 0)), WW'(0));
    chk("t1 first(4,4)", WW'(el(first_win[1], 4, 4)), WW'(36));
    chk("t1 last(0,0)", WW'(el(last_win[1], 0, 0)), WW'(27));
    chk("t1 last(4,4)", WW'(el(last_win[1], 4, 4)), WW'(63));

    // IS=6 FS=3, in_valid toggling
    start_frame(6, 3);
    feed(2, 6, 3, 0, 36, 1'b1, -1);
    wait_drain(2, 16, "t2");
    chk("t2 out_valid_spacing", WW'(ov_cyc[2][1] - ov_cyc[2][0]), WW'(2));
    chk("t2 last(2,2)", WW'(el(last_win[2], 2, 2)), WW'(35));

    // IS=4 FS=1
    start_frame(4, 1);
    feed(3, 4, 1, 0, 16, 1'b0, -1);
    wait_drain(3, 16, "t3");
    chk("t3 last(0,0)", WW'(el(last_win[3], 0, 0)), WW'(15));
    chk("t3 last(0,1)", WW'(el(last_win[3], 0, 1)), WW'(0));

    // back-to-back frames, restart on the frame_done cycle
    start_frame(5, 3);
    feed(4, 5, 3, 0, 25, 1'b0, -1);
    tick();
    chk("t4 frame_done_at_restart", WW'(frame_done), WW'(1));
    start_frame(7, 5);
    feed(5, 7, 5, 100, 49, 1'b0, -1);
    wait_drain(5, 9, "t4b");
    chk("t4a window_count", WW'(win_cnt[4]), WW'(9));
    chk("t4b first(0,0)", WW'(el(first_win[5], 0, 0)), WW'(100));
    chk("t4b first(4,4)", WW'(el(first_win[5], 4, 4)), WW'(132));

    // reset in the middle of row 3, then a clean frame
    start_frame(8, 5);
    feed(6, 8, 5, 200, 3 * 8 + 4, 1'b0, -1);
    #1 xrst = 1'b0;
    #1;
    chk("t5 reset win_out", win_out, '0);
    chk("t5 reset out_valid", WW'(out_valid), WW'(0));
    chk("t5 reset frame_done", WW'(frame_done), WW'(0));
    chk("t5 reset busy", WW'(busy), WW'(0));
    #1 xrst = 1'b1;
    tick();
    chk("t5 aborted_windows", WW'(win_cnt[6]), WW'(0));
    start_frame(8, 5);
    feed(7, 8, 5, 300, 64, 1'b0, -1);
    wait_drain(7, 16, "t5");
    chk("t5 first(0,0)", WW'(el(first_win[7], 0, 0)), WW'(300));
    chk("t5 last(4,4)", WW'(el(last_win[7], 4, 4)), WW'(363));

    // fil_size above MAXFIL saturates; buf_en while active is ignored
    start_frame(6, 7);
    feed(8, 6, 5, 0, 36, 1'b0, 4 * 6 + 2);
    wait_drain(8, 4, "t6");
    chk("t6 first(0,0)", WW'(el(first_win[8], 0, 0)), WW'(0));
    chk("t6 last(4,4)", WW'(el(last_win[8], 4, 4)), WW'(35));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
